// File: rtl/ex_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-register fields in, forwarding/stall/flush controls out.
interface ex_hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_valid;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       branch_taken;
  logic [4:0] mem_rd;
  logic [4:0] wb_rd;
  logic       mem_reg_write;
  logic       wb_reg_write;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall_if;
  logic       stall_id;
  logic       bubble_ex;
  logic       flush_id;
  logic       flush_ex;
  logic       redirect;
  logic       busy;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_valid, ex_rs1, ex_rs2, ex_rd, ex_mem_read, branch_taken,
    output mem_rd, wb_rd, mem_reg_write, wb_reg_write,
    input  fwd_a_sel, fwd_b_sel, stall_if, stall_id, bubble_ex,
    input  flush_id, flush_ex, redirect, busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_valid, ex_rs1, ex_rs2, ex_rd, ex_mem_read, branch_taken,
    input  mem_rd, wb_rd, mem_reg_write, wb_reg_write,
    output fwd_a_sel, fwd_b_sel, stall_if, stall_id, bubble_ex,
    output flush_id, flush_ex, redirect, busy
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use stalls, branch flush/redirect.
// Optional macro HAZARD_PERF_EN adds stall_count/flush_count performance counters.
module ex_hazard_ctrl #(
  parameter int FLUSH_CYCLES      = 1,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  ex_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]    stall_count,
  output logic [31:0]    flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Counter reloads hold the number of extra cycles beyond the triggering one, minus one.
  localparam logic [2:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
  localparam logic [2:0] STALL_RELOAD = (LOAD_STALL_CYCLES > 1) ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;

  state_e     state_r, state_nx_s;
  logic [2:0] cnt_r, cnt_nx_s;
  logic       busy_r;
  logic       hazard_s, taken_s;
  logic       stall_s, flush_s, redirect_s;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       mem_we,
    input logic [4:0] mem_dst,
    input logic       wb_we,
    input logic [4:0] wb_dst
  );
    logic [1:0] sel;
    if (mem_we && (mem_dst != 5'd0) && (mem_dst == rs)) begin
      sel = 2'd1;
    end else if (wb_we && (wb_dst != 5'd0) && (wb_dst == rs)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  assign hazard_s = hz.id_valid && hz.ex_valid && hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
  assign taken_s  = hz.ex_valid && hz.branch_taken;

  // Next-state and Mealy control outputs; a taken branch outranks any stall.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    stall_s    = 1'b0;
    flush_s    = 1'b0;
    redirect_s = 1'b0;
    if (rst) begin
      state_nx_s = ST_RUN;
      cnt_nx_s   = 3'd0;
    end else begin
      case (state_r)
        ST_RUN, ST_STALL: begin
          if (taken_s) begin
            redirect_s = 1'b1;
            flush_s    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nx_s = ST_FLUSH;
              cnt_nx_s   = FLUSH_RELOAD;
            end else begin
              state_nx_s = ST_RUN;
              cnt_nx_s   = 3'd0;
            end
          end else if (state_r == ST_STALL) begin
            stall_s = 1'b1;
            if (cnt_r == 3'd0) begin
              state_nx_s = ST_RUN;
            end else begin
              cnt_nx_s = cnt_r - 3'd1;
            end
          end else if (hazard_s) begin
            stall_s = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nx_s = ST_STALL;
              cnt_nx_s   = STALL_RELOAD;
            end else begin
              state_nx_s = ST_RUN;
              cnt_nx_s   = 3'd0;
            end
          end else begin
            state_nx_s = ST_RUN;
          end
        end
        ST_FLUSH: begin
          // EX only holds squashed bubbles here, so branch and load-use inputs are ignored.
          flush_s = 1'b1;
          if (cnt_r == 3'd0) begin
            state_nx_s = ST_RUN;
          end else begin
            cnt_nx_s = cnt_r - 3'd1;
          end
        end
        default: begin
          state_nx_s = ST_RUN;
          cnt_nx_s   = 3'd0;
        end
      endcase
    end
  end

  // State, counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
      cnt_r   <= 3'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      busy_r  <= (state_nx_s != ST_RUN);
    end
  end

  assign hz.fwd_a_sel = fwd_sel(hz.ex_rs1, hz.mem_reg_write, hz.mem_rd, hz.wb_reg_write, hz.wb_rd);
  assign hz.fwd_b_sel = fwd_sel(hz.ex_rs2, hz.mem_reg_write, hz.mem_rd, hz.wb_reg_write, hz.wb_rd);
  assign hz.stall_if  = stall_s;
  assign hz.stall_id  = stall_s;
  assign hz.bubble_ex = stall_s;
  assign hz.flush_id  = flush_s;
  assign hz.flush_ex  = flush_s;
  assign hz.redirect  = redirect_s;
  assign hz.busy      = busy_r;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_r, flush_count_r;

  // Performance counters; flush_count counts branches that were acted on.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_r <= 32'd0;
      flush_count_r <= 32'd0;
    end else begin
      if (stall_s) begin
        stall_count_r <= stall_count_r + 32'd1;
      end
      if (redirect_s) begin
        flush_count_r <= flush_count_r + 32'd1;
      end
    end
  end

  assign stall_count = stall_count_r;
  assign flush_count = flush_count_r;
`endif

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Pipeline hazard controller for the execute stage that sequences the ALU in the 5-stage RISC-V core. Forwarding: selects ALU operand sources. Load-use: inserts stall bubbles. Taken branch/JAL: when the ALU reports one, flushes the younger instructions and redirects fetch. Sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and the IF/ID stall/flush controls.

Parameters:
FLUSH_CYCLES, 1, cycles flush_id/flush_ex stay asserted after a taken branch (1..7)
LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (1..7)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active high
id_valid  in  1  valid instruction in ID
id_rs1, id_rs2  in  5  ID source registers
id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1/rs2
ex_valid  in  1  valid instruction in EX
ex_rs1, ex_rs2  in  5  EX source registers
ex_rd  in  5  EX destination
ex_mem_read  in  1  EX instruction is a load
branch_taken  in  1  ALU branch/jump resolution
mem_rd, wb_rd  in  5  MEM/WB destinations
mem_reg_write, wb_reg_write  in  1  MEM/WB write enables
fwd_a_sel, fwd_b_sel  out  2  ALU in1/in2 source: 0 regfile, 1 EX/MEM result, 2 MEM/WB result
stall_if, stall_id  out  1  hold PC and IF/ID register
bubble_ex  out  1  load NOP into ID/EX
flush_id, flush_ex  out  1  invalidate IF/ID and ID/EX
redirect  out  1  PC takes branch target this cycle
busy  out  1  FSM not in RUN

Behaviour:
- clk and rst as in Ports; rst is synchronous, active high.
- Reset: state RUN, counter 0. Outputs all 0 except fwd sels follow combinational inputs.
- Forwarding, combinational, per operand (rs = ex_rs1 for A, ex_rs2 for B):
  - sel=1 if mem_reg_write & mem_rd!=0 & mem_rd==rs.
  - Else sel=2 if wb_reg_write & wb_rd!=0 & wb_rd==rs.
  - Else 0. MEM beats WB.
- Load-use hazard H = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Taken event T = ex_valid & branch_taken.
- FSM states RUN, STALL, FLUSH. 3-bit down counter cnt.
- RUN:
  - T: redirect=1, flush_id=flush_ex=1 same cycle (Mealy). If FLUSH_CYCLES>1: next state FLUSH, cnt=FLUSH_CYCLES-2; else stay RUN.
  - else H: stall_if=stall_id=bubble_ex=1 same cycle. If LOAD_STALL_CYCLES>1: next state STALL, cnt=LOAD_STALL_CYCLES-2; else stay RUN.
  - T has priority over H; the ID instruction is killed, so no stall.
- STALL:
  - stall_if=stall_id=bubble_ex=1.
  - cnt==0 -> RUN, else cnt-1.
  - T (ex_valid set by external logic) preempts: act as in RUN-T, enter FLUSH/RUN accordingly.
- FLUSH:
  - flush_id=flush_ex=1, redirect=0.
  - H ignored. T ignored; EX holds flushed bubbles.
  - cnt==0 -> RUN, else cnt-1.
- busy=1 iff state!=RUN (registered).
- stall and flush are never asserted together except through the T-in-STALL preemption; flush wins there, stall outputs 0 that cycle.
- rst mid-STALL/FLUSH: return to RUN next edge, all controls 0.
- Back-to-back loads: each hazard handled independently on return to RUN.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: extra outputs stall_count[31:0] and flush_count[31:0].
  - stall_count increments on every cycle with stall_id=1.
  - flush_count increments once per T event.
  - Both wrap at 2^32 and clear on rst.
- Not defined: ports absent, no counter logic.

Test Plan:
- Forwarding: ex_rs1=5, mem_rd=5, mem_reg_write=1, wb_rd=5, wb_reg_write=1 -> fwd_a_sel=1. Clear mem_reg_write -> 2. Repeat with rs=0 -> 0.
- Load-use, default params: ex_mem_read=1, ex_rd=7, id_rs2=7, id_uses_rs2=1, valids=1 -> stall_if/stall_id/bubble_ex=1 for exactly 1 cycle. busy stays 0.
- Load-use, LOAD_STALL_CYCLES=3 -> stall asserted 3 consecutive cycles, busy=1 for cycles 2-3, then RUN.
- Branch, FLUSH_CYCLES=2: branch_taken=1, ex_valid=1 -> redirect 1 cycle, flush_id/flush_ex 2 cycles. H during FLUSH ignored.
- Simultaneous T and H -> flush/redirect=1, stall_if=0. Same branch_taken with ex_valid=0 -> no action.
- rst asserted in STALL cycle 2 of 3 -> next cycle all controls 0, busy=0. With HAZARD_PERF_EN, counters read 0.
